aixh_mxc_bwd_collector: RTL and testbench
=========================================

# aixh_mxc_bwd_collector

Receiving end of the MxConv backward (bwd) result path: one instance sits at the x=0 edge of each ptile row and absorbs the per-cell `bwd_vld`/`bwd_dat` stream the array emits. The array has no backpressure, so the block buffers each nonzero beat in a small FIFO. It then serializes the valid cells of the head beat onto a valid/ready result port in ascending cell order. Beats that arrive while the FIFO is full are dropped and flagged.

## Interface
- `YCELLS`, default 4: cells per row, i.e. width of `i_bwd_vld`; must be ≥2.
- `CELL_DWIDTH`, default 32: result width per cell.
- `DEPTH`, default 4: FIFO entries, in beats; must be a power of two and ≥2.
- `aixh_core_clk2x`, in, 1: sole clock; all state is rising-edge.
- `aixh_core_rstn2x`, in, 1: reset, asynchronous active-low.
- `i_bwd_vld`, in, YCELLS: per-cell valid of the incoming beat; bit c qualifies cell c.
- `i_bwd_dat`, in, YCELLS*CELL_DWIDTH: cell c occupies bits `[CELL_DWIDTH*c +: CELL_DWIDTH]`.
- `o_res_vld`, out, 1: a result is offered.
- `i_res_rdy`, in, 1: consumer accepts; transfer = `o_res_vld & i_res_rdy`.
- `o_res_dat`, out, CELL_DWIDTH: offered cell result.
- `o_res_idx`, out, $clog2(YCELLS): cell index of the offered result.
- `o_res_last`, out, 1: offered cell is the highest remaining valid cell of its beat.
- `o_fifo_lvl`, out, $clog2(DEPTH)+1: number of beats stored, including the head.
- `o_ovf`, out, 1: sticky flag, set when a beat is dropped.
- `i_ovf_clr`, in, 1: clears `o_ovf` and, when compiled in, the drop counter.
- `o_drop_cnt`, out, 16: dropped-beat count; exists only with the macro.

## Operation
- Beat = one cycle's `(i_bwd_vld, i_bwd_dat)`. A beat with `i_bwd_vld == 0` is ignored and never stored.
- FIFO entry = {mask[YCELLS], data[YCELLS*CELL_DWIDTH]}. A nonzero beat is written at the rising edge of its cycle.
- Push condition: `|i_bwd_vld & (!full | head_pop)`.
  - `head_pop` = transfer of the head's last cell in the same cycle, so a full FIFO accepts a beat on the cycle it frees a slot.
- Drop condition: `|i_bwd_vld & full & !head_pop`. The beat is discarded, `o_ovf` is set next cycle, and `o_drop_cnt` increments, saturating at 0xFFFF.
- Serializer FSM, two states:
  - IDLE: FIFO is empty and `o_res_vld = 0`. Moves to DRAIN when `o_fifo_lvl` becomes nonzero.
  - DRAIN: a working mask `wmask` is loaded from the head mask.
    - `o_res_idx` = index of the lowest set bit of `wmask`; `o_res_dat` = that cell's slice.
    - `o_res_last = (wmask has exactly one bit set)`.
    - On a transfer, that bit is cleared in `wmask`.
    - On the transfer with `o_res_last=1`, the head is popped and `wmask` reloads from the next entry. The FSM stays in DRAIN if an entry remains, otherwise returns to IDLE.
- `o_res_vld`, `o_res_dat`, `o_res_idx` and `o_res_last` are held stable while `o_res_vld & !i_res_rdy`.
- `i_ovf_clr` together with a drop in the same cycle: the drop wins. `o_ovf` reads 1, and the counter reads 1 when compiled in.
- Pointers wrap modulo DEPTH. Full means `lvl==DEPTH`; empty means `lvl==0`.

## Timing
- Reset values: `o_res_vld=0`, `o_res_dat=0`, `o_res_idx=0`, `o_res_last=0`, `o_fifo_lvl=0`, `o_ovf=0`, `o_drop_cnt=0`. FSM resets to IDLE and `wmask=0`. FIFO contents are don't-care.
- Latency: a beat at cycle N into an empty FIFO drives `o_res_vld=1` at cycle N+1 with its lowest valid cell.
- Throughput: one cell per cycle while `i_res_rdy=1`, with no bubble between beats. A beat with k valid cells takes k cycles to drain.
- `o_fifo_lvl` updates one cycle after a push or pop. A simultaneous push and pop leaves it unchanged.
- Reset asserted mid-drain takes effect asynchronously. All outputs return to their reset values, and any partially drained beat and stored beats are lost.
- All outputs are registered. There is no combinational path from `i_bwd_*` or `i_res_rdy` to any output.

## Configuration
- `AIXH_MXC_BWD_COLLECTOR_DROPCNT_EN`: when defined, the 16-bit saturating `o_drop_cnt` port and register exist and are cleared by `i_ovf_clr`. When undefined, the port is absent and only the sticky `o_ovf` reports drops. All other behaviour is identical.

## Test plan
- Reset, then one beat with vld=4'b1010, data cells {c3=0x33, c1=0x11}, and `i_res_rdy=1`:
  - expect (idx=1, dat=0x11, last=0) at N+1, then (idx=3, dat=0x33, last=1) at N+2, then `o_res_vld=0`.
- `i_res_rdy=0`, 5 beats of vld=4'b1111 (DEPTH=4):
  - `o_fifo_lvl` reaches 4 and the 5th beat is dropped;
  - `o_ovf=1`; `o_drop_cnt=1` with the macro;
  - the first offered result is held stable with idx=0 throughout.
- Full FIFO with the head holding one remaining cell, `i_res_rdy=1`, and a new beat vld=4'b0001 arriving on that same cycle:
  - the beat is accepted, `o_fifo_lvl` stays 4, and `o_ovf` stays 0.
- Beat vld=4'b0000 with nonzero data:
  - no push, `o_fifo_lvl=0`, `o_res_vld` stays 0.
- Back-to-back beats 4'b1111, 4'b0100, 4'b1001 with `i_res_rdy=1`:
  - 7 consecutive transfers with idx 0,1,2,3,2,0,3;
  - `o_res_last` high on idx 3, 2 and 3;
  - no idle cycle between transfers.
- Drain in progress with `o_ovf=1`: assert `aixh_core_rstn2x=0` asynchronously mid-cycle:
  - all outputs are 0 immediately;
  - after release, a new beat 4'b0100 with c2=0x7 appears as (idx=2, dat=0x7, last=1) one cycle later.

Source files
------------

// File: rtl/aixh_mxc_bwd_collector.sv
// MxConv backward-result collector: buffers nonzero bwd beats and serializes their valid cells onto a valid/ready port.
// Optional feature: define AIXH_MXC_BWD_COLLECTOR_DROPCNT_EN for a 16-bit saturating dropped-beat counter.
module aixh_mxc_bwd_collector #(
    parameter int unsigned YCELLS      = 4,
    parameter int unsigned CELL_DWIDTH = 32,
    parameter int unsigned DEPTH       = 4
) (
    input  logic                            aixh_core_clk2x,
    input  logic                            aixh_core_rstn2x,
    input  logic [YCELLS-1:0]               i_bwd_vld,
    input  logic [YCELLS*CELL_DWIDTH-1:0]   i_bwd_dat,
    output logic                            o_res_vld,
    input  logic                            i_res_rdy,
    output logic [CELL_DWIDTH-1:0]          o_res_dat,
    output logic [$clog2(YCELLS)-1:0]       o_res_idx,
    output logic                            o_res_last,
    output logic [$clog2(DEPTH):0]          o_fifo_lvl,
    output logic                            o_ovf,
    input  logic                            i_ovf_clr
`ifdef AIXH_MXC_BWD_COLLECTOR_DROPCNT_EN
    ,
    output logic [15:0]                     o_drop_cnt
`endif
);

    localparam int unsigned IDX_W  = $clog2(YCELLS);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned LVL_W  = PTR_W + 1;
    localparam int unsigned BEAT_W = YCELLS * CELL_DWIDTH;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t                  state, state_nxt;
    logic [YCELLS-1:0]       mem_mask [DEPTH];
    logic [BEAT_W-1:0]       mem_dat  [DEPTH];
    logic [PTR_W-1:0]        wptr, rptr, rptr_nxt;
    logic [YCELLS-1:0]       wmask, wmask_nxt;
    logic [LVL_W-1:0]        lvl_nxt, lvl_rem;
    logic                    any_vld, full, transfer, head_pop, push, drop;
    logic [YCELLS-1:0]       head_mask_nxt;
    logic [BEAT_W-1:0]       head_dat_nxt;
    logic                    res_vld_nxt, res_last_nxt;
    logic [IDX_W-1:0]        res_idx_nxt;
    logic [CELL_DWIDTH-1:0]  res_dat_nxt;

    function automatic logic [IDX_W-1:0] low_idx(input logic [YCELLS-1:0] m);
        low_idx = '0;
        for (int i = int'(YCELLS) - 1; i >= 0; i--) begin
            if (m[i]) low_idx = IDX_W'(i);
        end
    endfunction

    // Push/pop bookkeeping; a full FIFO still accepts when the head retires this cycle.
    always_comb begin
        any_vld  = |i_bwd_vld;
        full     = (o_fifo_lvl == LVL_W'(DEPTH));
        transfer = o_res_vld & i_res_rdy;
        head_pop = transfer & o_res_last;
        push     = any_vld & (~full | head_pop);
        drop     = any_vld & full & ~head_pop;
        lvl_rem  = o_fifo_lvl - LVL_W'(head_pop);
        lvl_nxt  = lvl_rem + LVL_W'(push);
        rptr_nxt = rptr + PTR_W'(head_pop);
    end

    // Next-cycle head entry; bypasses the incoming beat when it lands in an otherwise empty FIFO.
    always_comb begin
        head_mask_nxt = mem_mask[rptr_nxt];
        head_dat_nxt  = mem_dat[rptr_nxt];
        if (lvl_rem == '0) begin
            head_mask_nxt = i_bwd_vld;
            head_dat_nxt  = i_bwd_dat;
        end
    end

    always_ff @(posedge aixh_core_clk2x or negedge aixh_core_rstn2x) begin
        if (!aixh_core_rstn2x) state <= S_IDLE;
        else                   state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (lvl_nxt != '0) state_nxt = S_DRAIN;
            S_DRAIN: if (head_pop && lvl_nxt == '0) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Working-mask update and next values of the registered result port.
    always_comb begin
        wmask_nxt = wmask;
        case (state)
            S_IDLE: wmask_nxt = (lvl_nxt != '0) ? head_mask_nxt : '0;
            S_DRAIN: begin
                if (head_pop)      wmask_nxt = (lvl_nxt != '0) ? head_mask_nxt : '0;
                else if (transfer) wmask_nxt = wmask & (wmask - YCELLS'(1));
            end
            default: wmask_nxt = '0;
        endcase
        res_vld_nxt  = (wmask_nxt != '0);
        res_idx_nxt  = low_idx(wmask_nxt);
        res_last_nxt = res_vld_nxt && ((wmask_nxt & (wmask_nxt - YCELLS'(1))) == '0);
        res_dat_nxt  = '0;
        for (int c = 0; c < int'(YCELLS); c++) begin
            if (res_vld_nxt && IDX_W'(c) == res_idx_nxt)
                res_dat_nxt = head_dat_nxt[c*CELL_DWIDTH +: CELL_DWIDTH];
        end
    end

    always_ff @(posedge aixh_core_clk2x) begin
        if (push) begin
            mem_mask[wptr] <= i_bwd_vld;
            mem_dat[wptr]  <= i_bwd_dat;
        end
    end

    always_ff @(posedge aixh_core_clk2x or negedge aixh_core_rstn2x) begin
        if (!aixh_core_rstn2x) begin
            wptr       <= '0;
            rptr       <= '0;
            wmask      <= '0;
            o_fifo_lvl <= '0;
            o_res_vld  <= 1'b0;
            o_res_dat  <= '0;
            o_res_idx  <= '0;
            o_res_last <= 1'b0;
        end else begin
            wptr       <= wptr + PTR_W'(push);
            rptr       <= rptr_nxt;
            wmask      <= wmask_nxt;
            o_fifo_lvl <= lvl_nxt;
            o_res_vld  <= res_vld_nxt;
            o_res_dat  <= res_dat_nxt;
            o_res_idx  <= res_idx_nxt;
            o_res_last <= res_last_nxt;
        end
    end

    // Sticky overflow; a drop outranks a same-cycle clear.
    always_ff @(posedge aixh_core_clk2x or negedge aixh_core_rstn2x) begin
        if (!aixh_core_rstn2x) o_ovf <= 1'b0;
        else if (drop)         o_ovf <= 1'b1;
        else if (i_ovf_clr)    o_ovf <= 1'b0;
    end

`ifdef AIXH_MXC_BWD_COLLECTOR_DROPCNT_EN
    always_ff @(posedge aixh_core_clk2x or negedge aixh_core_rstn2x) begin
        if (!aixh_core_rstn2x) begin
            o_drop_cnt <= '0;
        end else if (drop) begin
            if (i_ovf_clr)                   o_drop_cnt <= 16'd1;
            else if (o_drop_cnt != 16'hFFFF) o_drop_cnt <= o_drop_cnt + 16'd1;
        end else if (i_ovf_clr) begin
            o_drop_cnt <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_aixh_mxc_bwd_collector.sv
// Scoreboard bench for aixh_mxc_bwd_collector: directed scenarios plus random traffic against a queue-based model.
module tb_aixh_mxc_bwd_collector;

    localparam int unsigned YC  = 4;
    localparam int unsigned DW  = 32;
    localparam int unsigned DEP = 4;

    logic              clk;
    logic              rstn;
    logic [YC-1:0]     i_bwd_vld;
    logic [YC*DW-1:0]  i_bwd_dat;
    logic              o_res_vld;
    logic              i_res_rdy;
    logic [DW-1:0]     o_res_dat;
    logic [1:0]        o_res_idx;
    logic              o_res_last;
    logic [2:0]        o_fifo_lvl;
    logic              o_ovf;
    logic              i_ovf_clr;
`ifdef AIXH_MXC_BWD_COLLECTOR_DROPCNT_EN
    logic [15:0]       o_drop_cnt;
`endif

    aixh_mxc_bwd_collector #(.YCELLS(YC), .CELL_DWIDTH(DW), .DEPTH(DEP)) dut (
        .aixh_core_clk2x  (clk),
        .aixh_core_rstn2x (rstn),
        .i_bwd_vld        (i_bwd_vld),
        .i_bwd_dat        (i_bwd_dat),
        .o_res_vld        (o_res_vld),
        .i_res_rdy        (i_res_rdy),
        .o_res_dat        (o_res_dat),
        .o_res_idx        (o_res_idx),
        .o_res_last       (o_res_last),
        .o_fifo_lvl       (o_fifo_lvl),
        .o_ovf            (o_ovf),
        .i_ovf_clr        (i_ovf_clr)
`ifdef AIXH_MXC_BWD_COLLECTOR_DROPCNT_EN
        ,
        .o_drop_cnt       (o_drop_cnt)
`endif
    );

    typedef struct {
        logic [1:0]  idx;
        logic [31:0] dat;
        logic        last;
    } cell_t;

    cell_t       sb[$];     // expected cells, in offer order
    int          cnt_q[$];  // remaining cells per stored beat, head first
    logic        m_ovf;
    logic [15:0] m_cnt;
    int          n_checks;
    int          n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: account for the clock edge that just consumed the current inputs.
    task automatic model_edge();
        logic xfer, hpop, full, any;
        int   hi;
        if (!rstn) return;
        xfer = (cnt_q.size() > 0) && i_res_rdy;
        hpop = xfer && (cnt_q[0] == 1);
        full = (cnt_q.size() == int'(DEP));
        any  = |i_bwd_vld;
        if (xfer) begin
            cnt_q[0] = cnt_q[0] - 1;
            if (cnt_q[0] == 0) void'(cnt_q.pop_front());
        end
        if (any && (!full || hpop)) begin
            hi = 0;
            for (int c = 0; c < int'(YC); c++) if (i_bwd_vld[c]) hi = c;
            for (int c = 0; c < int'(YC); c++) begin
                if (i_bwd_vld[c]) sb.push_back('{idx: 2'(c), dat: i_bwd_dat[c*DW +: DW], last: (c == hi)});
            end
            cnt_q.push_back($countones(i_bwd_vld));
        end
        if (any && full && !hpop) begin
            m_ovf = 1'b1;
            if (i_ovf_clr)              m_cnt = 16'd1;
            else if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end else if (i_ovf_clr) begin
            m_ovf = 1'b0;
            m_cnt = 16'd0;
        end
    endtask

    task automatic step(input logic [3:0] v, input logic [127:0] d, input logic r, input logic c);
        @(posedge clk);
        #1;
        model_edge();
        i_bwd_vld = v;
        i_bwd_dat = d;
        i_res_rdy = r;
        i_ovf_clr = c;
    endtask

    task automatic drain();
        for (int i = 0; i < 64; i++) begin
            if (cnt_q.size() == 0) break;
            step(4'b0000, '0, 1'b1, 1'b0);
        end
        step(4'b0000, '0, 1'b1, 1'b0);
        chk("drain_done", 32'(cnt_q.size()), 32'd0);
    endtask

    function automatic logic [127:0] rnd_dat();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic void model_clear();
        sb.delete();
        cnt_q.delete();
        m_ovf = 1'b0;
        m_cnt = 16'd0;
    endfunction

    // Monitor: compares the presented result against the scoreboard head each cycle.
    always @(negedge clk) begin
        chk("res_vld", 32'(o_res_vld), 32'(sb.size() != 0));
        if (o_res_vld && sb.size() != 0) begin
            chk("res_idx", 32'(o_res_idx), 32'(sb[0].idx));
            chk("res_dat", o_res_dat, sb[0].dat);
            chk("res_last", 32'(o_res_last), 32'(sb[0].last));
            if (i_res_rdy) void'(sb.pop_front());
        end
        chk("fifo_lvl", 32'(o_fifo_lvl), 32'(cnt_q.size()));
        chk("ovf", 32'(o_ovf), 32'(m_ovf));
`ifdef AIXH_MXC_BWD_COLLECTOR_DROPCNT_EN
        chk("drop_cnt", 32'(o_drop_cnt), 32'(m_cnt));
`endif
    end

    initial begin
        logic [127:0] d;
        n_checks  = 0;
        n_fail    = 0;
        model_clear();
        rstn      = 1'b0;
        i_bwd_vld = '0;
        i_bwd_dat = '0;
        i_res_rdy = 1'b0;
        i_ovf_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        step(4'b0000, '0, 1'b1, 1'b0);

        // Single sparse beat
        d = '0;
        d[1*DW +: DW] = 32'h11;
        d[3*DW +: DW] = 32'h33;
        step(4'b1010, d, 1'b1, 1'b0);
        repeat (3) step(4'b0000, '0, 1'b1, 1'b0);

        // Fill while stalled, overflow, then a drop coinciding with a clear
        repeat (5) step(4'b1111, rnd_dat(), 1'b0, 1'b0);
        step(4'b1111, rnd_dat(), 1'b0, 1'b1);
        repeat (2) step(4'b0000, '0, 1'b0, 1'b0);
        step(4'b0000, '0, 1'b0, 1'b1);

        // Full FIFO accepts a beat on the cycle its head retires
        repeat (3) step(4'b0000, '0, 1'b1, 1'b0);
        step(4'b0001, rnd_dat(), 1'b1, 1'b0);
        drain();

        // All-invalid beat with nonzero data
        repeat (2) step(4'b0000, rnd_dat(), 1'b1, 1'b0);

        // Back-to-back beats
        step(4'b1111, rnd_dat(), 1'b1, 1'b0);
        step(4'b0100, rnd_dat(), 1'b1, 1'b0);
        step(4'b1001, rnd_dat(), 1'b1, 1'b0);
        drain();

        // Asynchronous reset in the middle of a drain with overflow set
        repeat (5) step(4'b1111, rnd_dat(), 1'b0, 1'b0);
        repeat (2) step(4'b0000, '0, 1'b1, 1'b0);
        #2;
        rstn = 1'b0;
        #1;
        chk("rst_res_vld", 32'(o_res_vld), 32'd0);
        chk("rst_res_dat", o_res_dat, 32'd0);
        chk("rst_res_idx", 32'(o_res_idx), 32'd0);
        chk("rst_res_last", 32'(o_res_last), 32'd0);
        chk("rst_fifo_lvl", 32'(o_fifo_lvl), 32'd0);
        chk("rst_ovf", 32'(o_ovf), 32'd0);
`ifdef AIXH_MXC_BWD_COLLECTOR_DROPCNT_EN
        chk("rst_drop_cnt", 32'(o_drop_cnt), 32'd0);
`endif
        model_clear();
        i_bwd_vld = '0;
        i_bwd_dat = '0;
        i_res_rdy = 1'b0;
        i_ovf_clr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        d = '0;
        d[2*DW +: DW] = 32'h7;
        step(4'b0100, d, 1'b1, 1'b0);
        repeat (2) step(4'b0000, '0, 1'b1, 1'b0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [3:0] v;
            v = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            step(v, rnd_dat(), ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
